// File: rtl/dense_seq_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed dense layer.
package dense_seq_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  // Upper bound on accumulator width that sat_shift can handle.
  localparam int ACC_MAX = 128;

  typedef struct packed {
    logic signed [ACC_MAX-1:0] word;
    logic                      clip;
  } sat_t;

  function automatic int acc_width(input int width, input int input_size);
    return 2 * width + $clog2(input_size) + 1;
  endfunction

  // Floor-shift by nfrac, then clamp to the signed range of a width-bit word.
  function automatic sat_t sat_shift(input logic signed [ACC_MAX-1:0] acc,
                                     input int nfrac, input int width);
    logic signed [ACC_MAX-1:0] s;
    logic signed [ACC_MAX-1:0] lo;
    logic signed [ACC_MAX-1:0] hi;
    sat_t r;
    s  = acc >>> nfrac;
    lo = '1;
    lo = lo <<< (width - 1);
    hi = ~lo;
    r.clip = (s > hi) || (s < lo);
    r.word = (s > hi) ? hi : ((s < lo) ? lo : s);
    return r;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One multiply-accumulate lane: full-precision signed product into a wide accumulator.
module dense_mac_lane #(
  parameter int WIDTH = 17,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/dense_layer_seq.sv
// Time-multiplexed dense layer: LANES neurons per group, runtime-loaded weights and biases.
module dense_layer_seq
  import dense_seq_pkg::*;
#(
  parameter int WIDTH       = 17,
  parameter int NFRAC       = 10,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 32,
  parameter int LANES       = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [WIDTH-1:0]                            in_data [0:INPUT_SIZE-1],
  input  logic                                        relu_en,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [WIDTH-1:0]                            out_data [0:OUTPUT_SIZE-1],
  output logic                                        ovf,
  input  logic                                        w_we,
  input  logic [$clog2(INPUT_SIZE*OUTPUT_SIZE)-1:0]   w_addr,
  input  logic [WIDTH-1:0]                            w_data,
  input  logic                                        b_we,
  input  logic [$clog2(OUTPUT_SIZE)-1:0]              b_addr,
  input  logic [WIDTH-1:0]                            b_data,
  output logic                                        cfg_err
);

  localparam int NW     = INPUT_SIZE * OUTPUT_SIZE;
  localparam int GROUPS = OUTPUT_SIZE / LANES;
  localparam int ACC_W  = acc_width(WIDTH, INPUT_SIZE);
  localparam int KW     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int WAW    = $clog2(NW);
  localparam int BAW    = $clog2(OUTPUT_SIZE);

  if (OUTPUT_SIZE % LANES != 0) begin : g_lanes_chk
    $error("OUTPUT_SIZE must be a multiple of LANES");
  end
  if (NFRAC >= WIDTH) begin : g_nfrac_chk
    $error("NFRAC must be less than WIDTH");
  end
  if (ACC_W > ACC_MAX) begin : g_acc_chk
    $error("accumulator wider than ACC_MAX");
  end

  logic signed [WIDTH-1:0] w_mem [0:NW-1];
  logic signed [WIDTH-1:0] b_mem [0:OUTPUT_SIZE-1];
  logic signed [WIDTH-1:0] x_q   [0:INPUT_SIZE-1];

  state_t          state;
  logic [KW-1:0]   k;
  logic [GW-1:0]   g;
  logic            relu_q;
  logic            busy;
  logic            w_bad;
  logic            b_bad;

  logic signed [WIDTH-1:0]   w_lane [LANES];
  logic signed [WIDTH-1:0]   b_lane [LANES];
  logic signed [ACC_W-1:0]   acc_q  [LANES];
  logic signed [ACC_MAX-1:0] sum_c  [LANES];
  sat_t                      sat_r  [LANES];
  logic [WIDTH-1:0]          res    [LANES];
  logic [LANES-1:0]          clip;

  assign busy  = (state == MAC) || (state == WB);
  assign w_bad = w_we && (busy || (32'(w_addr) >= 32'(NW)));
  assign b_bad = b_we && (busy || (32'(b_addr) >= 32'(OUTPUT_SIZE)));

  // Coefficient storage survives reset so a reset only aborts the vector in flight.
  always_ff @(posedge clk) begin
    if (w_we && !w_bad) w_mem[w_addr] <= w_data;
    if (b_we && !b_bad) b_mem[b_addr] <= b_data;
  end

  always_comb begin
    clip = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane[l] = w_mem[WAW'(32'(k) * 32'(OUTPUT_SIZE) + 32'(g) * 32'(LANES) + l)];
      b_lane[l] = b_mem[BAW'(32'(g) * 32'(LANES) + l)];
      sum_c[l]  = ACC_MAX'(acc_q[l]) + (ACC_MAX'(b_lane[l]) <<< NFRAC);
      sat_r[l]  = sat_shift(sum_c[l], NFRAC, WIDTH);
      clip[l]   = sat_r[l].clip;
      res[l]    = (relu_q && ($signed(sat_r[l].word) < 0)) ? '0 : sat_r[l].word[WIDTH-1:0];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (state == WB),
      .en     (state == MAC),
      .a      (x_q[k]),
      .b      (w_lane[l]),
      .acc    (acc_q[l])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      cfg_err   <= 1'b0;
      k         <= '0;
      g         <= '0;
      relu_q    <= 1'b0;
      for (int unsigned j = 0; j < OUTPUT_SIZE; j++) out_data[j] <= '0;
      for (int unsigned i = 0; i < INPUT_SIZE; i++) x_q[i] <= '0;
    end else begin
      cfg_err <= w_bad || b_bad;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int unsigned i = 0; i < INPUT_SIZE; i++) x_q[i] <= in_data[i];
            relu_q   <= relu_en;
            ovf      <= 1'b0;
            k        <= '0;
            g        <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MAC: begin
          if (k == KW'(INPUT_SIZE - 1)) begin
            k     <= '0;
            state <= WB;
          end else begin
            k <= k + 1'b1;
          end
        end
        WB: begin
          for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
            if (j / LANES == 32'(g)) out_data[j] <= res[j % LANES];
          end
          if (|clip) ovf <= 1'b1;
          if (g == GW'(GROUPS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            g     <= g + 1'b1;
            state <= MAC;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
